// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - phase encodings, light constants and phase helpers
package traffic_pkg;

   typedef enum logic [2:0] {
      S_G2    = 3'd0,
      S_Y2    = 3'd1,
      S_R1    = 3'd2,
      S_G1    = 3'd3,
      S_Y1    = 3'd4,
      S_R2    = 3'd5,
      S_FLASH = 3'd6
   } phase_e;

   localparam logic [2:0] RED       = 3'b100;
   localparam logic [2:0] YELLOW    = 3'b010;
   localparam logic [2:0] GREEN     = 3'b001;
   localparam logic [1:0] WALK      = 2'b01;
   localparam logic [1:0] DONT_WALK = 2'b10;

   function automatic logic is_green(input phase_e p);
      return (p == S_G1) || (p == S_G2);
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - divides clock into a one-cycle tick every TICK_DIV cycles
module tick_prescaler #(
   parameter int TICK_DIV = 50
) (
   input  logic clock,
   input  logic resetn,
   input  logic hold,
   output logic tick
);
   localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (!hold) begin
         count_d = (count_q == LAST) ? '0 : count_q + W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign tick = (count_q == LAST) && !hold;

endmodule

// File: rtl/traffic_phase_ctrl.sv
// rtl/traffic_phase_ctrl.sv - timed two-road intersection controller
// Optional night flash mode is enabled by defining TRAFFIC_NIGHT_FLASH_EN.
module traffic_phase_ctrl
   import traffic_pkg::*;
#(
   parameter int TICK_DIV        = 50,
   parameter int CNT_W           = 8,
   parameter int GREEN_TICKS     = 20,
   parameter int YELLOW_TICKS    = 4,
   parameter int ALLRED_TICKS    = 2,
   parameter int PED_SHORT_TICKS = 5
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       change,
   input  logic       hold,
`ifdef TRAFFIC_NIGHT_FLASH_EN
   input  logic       night,
`endif
   input  logic [1:0] ped_req,
   output logic [2:0] t1,
   output logic [2:0] t2,
   output logic [1:0] p1,
   output logic [1:0] p2,
   output logic [1:0] ped_pend,
   output logic [2:0] state
);
   localparam logic [CNT_W-1:0] G_LOAD     = CNT_W'(GREEN_TICKS - 1);
   localparam logic [CNT_W-1:0] Y_LOAD     = CNT_W'(YELLOW_TICKS - 1);
   localparam logic [CNT_W-1:0] AR_LOAD    = CNT_W'(ALLRED_TICKS - 1);
   localparam logic [CNT_W-1:0] SHORT_LOAD = CNT_W'(PED_SHORT_TICKS - 1);

   phase_e           phase_q, phase_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic [1:0]       walk_q, walk_d;
   logic [1:0]       pend_q, pend_d;
   logic             change_q;
   logic             tick, change_edge, shorten;
`ifdef TRAFFIC_NIGHT_FLASH_EN
   logic             flash_q, flash_d;
`endif

   tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
      .clock  (clock),
      .resetn (resetn),
      .hold   (hold),
      .tick   (tick)
   );

   function automatic phase_e next_phase(input phase_e p);
      case (p)
         S_G2:    return S_Y2;
         S_Y2:    return S_R1;
         S_R1:    return S_G1;
         S_G1:    return S_Y1;
         S_Y1:    return S_R2;
         default: return S_G2;
      endcase
   endfunction

   function automatic logic [CNT_W-1:0] load_for(input phase_e p);
      case (p)
         S_G1, S_G2: return G_LOAD;
         S_Y1, S_Y2: return Y_LOAD;
         default:    return AR_LOAD;
      endcase
   endfunction

   // Bit 0 is crossing 1 (walks with T1), bit 1 is crossing 2 (walks with T2);
   // a request cuts short the green of the opposing road.
   assign change_edge = change & ~change_q;
   assign shorten     = ((phase_q == S_G2 && ped_req[0]) || (phase_q == S_G1 && ped_req[1]))
                        && (timer_q > SHORT_LOAD);

   always_comb begin
      phase_d = phase_q;
      timer_d = timer_q;
      walk_d  = walk_q;
      pend_d  = pend_q | ped_req;
`ifdef TRAFFIC_NIGHT_FLASH_EN
      flash_d = flash_q;
      if (phase_q == S_FLASH) begin
         if (tick) begin
            if (night) begin
               flash_d = ~flash_q;
            end else begin
               phase_d = S_R2;
               timer_d = AR_LOAD;
            end
         end
      end else
`endif
      if (tick && timer_q == '0) begin
         phase_d = next_phase(phase_q);
`ifdef TRAFFIC_NIGHT_FLASH_EN
         if (night && (phase_q == S_R1 || phase_q == S_R2)) begin
            phase_d = S_FLASH;
            flash_d = 1'b1;
         end
`endif
         timer_d = load_for(phase_d);
         if (phase_d == S_G1) begin
            walk_d[0] = pend_q[0] | ped_req[0];
            pend_d[0] = 1'b0;
         end
         if (phase_d == S_G2) begin
            walk_d[1] = pend_q[1] | ped_req[1];
            pend_d[1] = 1'b0;
         end
      end else if (change_edge && is_green(phase_q)) begin
         timer_d = '0;
      end else if (shorten) begin
         timer_d = SHORT_LOAD;
      end else if (tick) begin
         timer_d = timer_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         phase_q  <= S_R2;
         timer_q  <= AR_LOAD;
         walk_q   <= '0;
         pend_q   <= '0;
         change_q <= 1'b0;
`ifdef TRAFFIC_NIGHT_FLASH_EN
         flash_q  <= 1'b0;
`endif
      end else begin
         phase_q  <= phase_d;
         timer_q  <= timer_d;
         walk_q   <= walk_d;
         pend_q   <= pend_d;
         change_q <= change;
`ifdef TRAFFIC_NIGHT_FLASH_EN
         flash_q  <= flash_d;
`endif
      end
   end

   always_comb begin
      t1 = RED;
      t2 = RED;
      p1 = DONT_WALK;
      p2 = DONT_WALK;
      case (phase_q)
         S_G1: begin
            t1 = GREEN;
            if (walk_q[0]) p1 = WALK;
         end
         S_Y1: t1 = YELLOW;
         S_G2: begin
            t2 = GREEN;
            if (walk_q[1]) p2 = WALK;
         end
         S_Y2: t2 = YELLOW;
`ifdef TRAFFIC_NIGHT_FLASH_EN
         S_FLASH: begin
            t1 = flash_q ? YELLOW : 3'b000;
            t2 = flash_q ? RED : 3'b000;
            p1 = 2'b00;
            p2 = 2'b00;
         end
`endif
         default: ;
      endcase
   end

   assign ped_pend = pend_q;
   assign state    = phase_q;

endmodule
